// File: rtl/med_pkg.sv
// Shared types and schedule constants for the MED median sequencer.
package med_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, CMP, ROT, DONE} state_t;

  localparam int         NB_PIXEL  = 9;
  localparam logic [2:0] LAST_PASS = 3'd4;
  localparam logic [3:0] LOAD_LEN  = 4'd9;

  // Compare cycles in one bubble pass; each pass fixes one more maximum.
  function automatic logic [3:0] cmp_len(input logic [2:0] pass);
    return 4'd8 - {1'b0, pass};
  endfunction

endpackage

// File: rtl/med.sv
// MED: 9-entry pixel ring with a compare-exchange between the last two slots.
// DSI shifts DI in; BYP=1 rotates the ring, BYP=0 keeps the larger value in the last slot.
module med #(
  parameter int SIZE = 8
) (
  input  logic            CLK,
  input  logic [SIZE-1:0] DI,
  input  logic            DSI,
  input  logic            BYP,
  output logic [SIZE-1:0] DO
);

  logic [SIZE-1:0] r [0:8];
  logic [SIZE-1:0] mx;
  logic [SIZE-1:0] mn;

  always_comb begin
    mx = r[8];
    mn = r[7];
    if (r[7] > r[8]) begin
      mx = r[7];
      mn = r[8];
    end
  end

  // Pixel storage carries no reset; contents are meaningless until loaded.
  always_ff @(posedge CLK) begin
    r[0] <= DSI ? DI : (BYP ? r[8] : mn);
    for (int k = 1; k < 8; k++) begin
      r[k] <= r[k-1];
    end
    r[8] <= BYP ? r[7] : mx;
  end

  assign DO = r[8];

endmodule

// File: rtl/med_seq.sv
// Sequencer for MED: loads a 9-pixel burst, runs the partial bubble-sort schedule
// and holds the median on a valid/ready output.
module med_seq #(
  parameter int SIZE     = 8,
  parameter int NB_PIXEL = 9
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [SIZE-1:0] DI,
  input  logic            DI_VALID,
  output logic            DI_READY,
  output logic [SIZE-1:0] DO,
  output logic            DO_VALID,
  input  logic            DO_READY,
  output logic            ERR
);

  import med_pkg::*;

  if (NB_PIXEL != med_pkg::NB_PIXEL) begin : g_bad_size
    $error("med_seq only supports a 9-pixel window");
  end

  state_t          state, state_n;
  logic [3:0]      cyc, cyc_n;
  logic [2:0]      pass, pass_n;
  logic [SIZE-1:0] do_n;
  logic            dov_n;
  logic            err_n;
  logic            dsi;
  logic            byp;
  logic [SIZE-1:0] med_do;

  med #(.SIZE(SIZE)) u_med (
    .CLK (CLK),
    .DI  (DI),
    .DSI (dsi),
    .BYP (byp),
    .DO  (med_do)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cyc      <= '0;
      pass     <= '0;
      DO       <= '0;
      DO_VALID <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state    <= state_n;
      cyc      <= cyc_n;
      pass     <= pass_n;
      DO       <= do_n;
      DO_VALID <= dov_n;
      ERR      <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    cyc_n    = cyc;
    pass_n   = pass;
    do_n     = DO;
    dov_n    = DO_VALID;
    err_n    = 1'b0;
    DI_READY = 1'b0;
    dsi      = 1'b0;
    byp      = 1'b1;
    unique case (state)
      IDLE: begin
        DI_READY = 1'b1;
        // The accepting IDLE cycle is already load cycle 0.
        dsi = DI_VALID;
        if (DI_VALID) begin
          state_n = LOAD;
          cyc_n   = 4'd1;
        end
      end
      LOAD: begin
        DI_READY = 1'b1;
        dsi      = 1'b1;
        if (DI_VALID) begin
          if (cyc == LOAD_LEN - 4'd1) begin
            state_n = CMP;
            cyc_n   = '0;
            pass_n  = '0;
          end else begin
            cyc_n = cyc + 4'd1;
          end
        end else begin
          // MED cannot stall, so a gap ruins the window.
          err_n   = 1'b1;
          state_n = IDLE;
          cyc_n   = '0;
        end
      end
      CMP: begin
        byp = 1'b0;
        if (pass == LAST_PASS && cyc == cmp_len(pass)) begin
          // The median reached MED's output slot on the previous edge.
          do_n    = med_do;
          dov_n   = 1'b1;
          state_n = DONE;
          cyc_n   = '0;
        end else if (pass != LAST_PASS && cyc == cmp_len(pass) - 4'd1) begin
          state_n = ROT;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc + 4'd1;
        end
      end
      ROT: begin
        if (cyc == {1'b0, pass}) begin
          state_n = CMP;
          cyc_n   = '0;
          pass_n  = pass + 3'd1;
        end else begin
          cyc_n = cyc + 4'd1;
        end
      end
      DONE: begin
        if (DO_READY) begin
          dov_n   = 1'b0;
          state_n = IDLE;
          pass_n  = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cyc_n   = '0;
        pass_n  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_med_seq.sv
// Directed and randomized checks of the med_seq median sequencer.
module tb_med_seq;

  typedef logic [7:0] win_t [9];

  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] DI;
  logic       DI_VALID;
  logic       DI_READY;
  logic [7:0] DO;
  logic       DO_VALID;
  logic       DO_READY;
  logic       ERR;

  int n_cmp = 0;
  int n_bad = 0;

  med_seq #(.SIZE(8), .NB_PIXEL(9)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .DI       (DI),
    .DI_VALID (DI_VALID),
    .DI_READY (DI_READY),
    .DO       (DO),
    .DO_VALID (DO_VALID),
    .DO_READY (DO_READY),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] median_of(input win_t w);
    logic [7:0] s [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) s[i] = w[i];
    for (int i = 1; i < 9; i++) begin
      for (int j = i; j > 0; j--) begin
        if (s[j-1] > s[j]) begin
          t = s[j]; s[j] = s[j-1]; s[j-1] = t;
        end
      end
    end
    return s[4];
  endfunction

  task automatic feed(input win_t w);
    for (int i = 0; i < 9; i++) begin
      DI       = w[i];
      DI_VALID = 1'b1;
      tick();
    end
    DI_VALID = 1'b0;
  endtask

  // Full burst: load, wait for the result, then complete the handshake after gap cycles.
  task automatic run_burst(input string tag, input win_t w, input logic [7:0] exp, input int gap, input bit detail);
    int n;
    DO_READY = (gap == 0);
    feed(w);
    if (detail) chk({tag, "_rdy_lo"}, int'(DI_READY), 0);
    n = 9;
    while (!DO_VALID && n < 200) begin
      if (detail && DI_READY) chk({tag, "_rdy_in_calc"}, int'(DI_READY), 0);
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 50);
    chk({tag, "_do"}, int'(DO), int'(exp));
    if (gap > 0) begin
      repeat (gap) tick();
      if (detail) begin
        chk({tag, "_hold_do"}, int'(DO), int'(exp));
        chk({tag, "_hold_vld"}, int'(DO_VALID), 1);
        chk({tag, "_hold_rdy"}, int'(DI_READY), 0);
      end
      DO_READY = 1'b1;
    end
    tick();
    chk({tag, "_vld_clr"}, int'(DO_VALID), 0);
    if (detail) chk({tag, "_idle_rdy"}, int'(DI_READY), 1);
  endtask

  initial begin
    win_t w;
    nRST     = 1'b0;
    DI       = '0;
    DI_VALID = 1'b0;
    DO_READY = 1'b0;
    #12;
    chk("rst_do", int'(DO), 0);
    chk("rst_vld", int'(DO_VALID), 0);
    chk("rst_rdy", int'(DI_READY), 1);
    chk("rst_err", int'(ERR), 0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    run_burst("ordered", w, 8'd5, 0, 1'b1);

    // Abort mid-compare; DO still holds 5 from the previous burst.
    w = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
    feed(w);
    repeat (6) tick();
    chk("midcmp_rdy", int'(DI_READY), 0);
    nRST = 1'b0;
    #1;
    chk("arst_do", int'(DO), 0);
    chk("arst_vld", int'(DO_VALID), 0);
    chk("arst_rdy", int'(DI_READY), 1);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    run_burst("after_rst", w, 8'd5, 0, 1'b1);

    w = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    run_burst("reverse", w, 8'd5, 0, 1'b1);
    w = '{8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 8'd255, 8'd255, 8'd7, 8'd3};
    run_burst("dups", w, 8'd7, 0, 1'b1);
    w = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    run_burst("all_ff", w, 8'd255, 0, 1'b1);
    w = '{8'd10, 8'd90, 8'd20, 8'd80, 8'd30, 8'd70, 8'd40, 8'd60, 8'd50};
    run_burst("backpress", w, 8'd50, 20, 1'b1);

    // Broken burst: five pixels then a gap.
    DO_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      DI       = 8'(i + 1);
      DI_VALID = 1'b1;
      tick();
    end
    DI_VALID = 1'b0;
    chk("brk_err_pre", int'(ERR), 0);
    tick();
    chk("brk_err", int'(ERR), 1);
    chk("brk_idle_rdy", int'(DI_READY), 1);
    tick();
    chk("brk_err_clr", int'(ERR), 0);
    repeat (60) begin
      if (DO_VALID) chk("brk_no_vld", int'(DO_VALID), 0);
      tick();
    end
    w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    run_burst("after_brk", w, 8'd5, 0, 1'b1);

    for (int b = 0; b < 1000; b++) begin
      for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
      if (b % 4 == 0) begin
        for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 3));
      end
      run_burst("rand", w, median_of(w), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
